// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg : active-low seven-segment glyphs {g,f,e,d,c,b,a} and index helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg_decoder.sv
// ---------------------------------------------------------------------------
// seg_decoder : combinational nibble to active-low segment lookup
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_MINUS;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_BLANK;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// seven_seg_scanner : time-multiplexed common-anode display driver, stepped by
// rising edges of a resynchronized scan_clk. SEVEN_SEG_LZ_BLANK_EN enables
// leading-zero blanking.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int NDIG        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scan_clk,
  input  logic [4*NDIG-1:0]       digits,
  input  logic [NDIG-1:0]         dp_mask,
  input  logic                    blank,
  output logic [NDIG-1:0]         anode,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [$clog2(NDIG)-1:0] digit_idx
);

  localparam int IW = idx_w(NDIG);
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   started_q;
  logic [IW-1:0]          idx_q,  idx_d;
  logic [3:0]             nib_q,  nib_d;
  logic                   dpb_q;
  logic [NDIG-1:0]        anode_q, anode_d;
  logic [6:0]             seg_q;
  logic                   dp_q;
  logic                   tick_w;
  logic [6:0]             dec_seg_w;

  assign tick_w = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);

  always_comb begin
    nib_d = digits[4*idx_d +: 4];
`ifdef SEVEN_SEG_LZ_BLANK_EN
    // Blank when this and every more-significant nibble is zero, no dp lit.
    if ((idx_d != '0) && !dp_mask[idx_d] && ((digits >> (4*idx_d)) == '0))
      nib_d = 4'hF;
`endif
  end

  always_comb begin
    anode_d = '1;
    if (started_q && !blank)
      anode_d = ~(NDIG'(1) << idx_q);
  end

  seg_decoder u_dec (
    .nib_i (nib_q),
    .seg_o (dec_seg_w)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      started_q <= 1'b0;
      idx_q     <= LAST_IDX;
      nib_q     <= 4'h0;
      dpb_q     <= 1'b0;
      anode_q   <= '1;
      seg_q     <= SEG_BLANK;
      dp_q      <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], scan_clk};
      prev_q <= sync_q[SYNC_STAGES-1];
      if (tick_w) begin
        // Dark for one clk while the new digit's snapshot settles.
        started_q <= 1'b1;
        idx_q     <= idx_d;
        nib_q     <= nib_d;
        dpb_q     <= dp_mask[idx_d];
        anode_q   <= '1;
      end else begin
        anode_q <= anode_d;
        if (started_q) begin
          seg_q <= dec_seg_w;
          dp_q  <= ~dpb_q;
        end
      end
    end
  end

  assign anode     = anode_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_idx = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scanner : scoreboard bench for seven_seg_scanner
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seven_seg_scanner;

  localparam int NDIG = 4;

  typedef struct {
    int         idx;
    logic [3:0] an;
    logic [6:0] sg;
    logic       dp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scan_clk = 1'b0;
  logic [15:0] digits = 16'h1234;
  logic [3:0]  dp_mask = 4'h0;
  logic        blank = 1'b0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;

  int   n_chk = 0;
  int   n_err = 0;
  int   m_idx = NDIG - 1;
  exp_t q[$];

  seven_seg_scanner #(.NDIG(NDIG), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_clk  (scan_clk),
    .digits    (digits),
    .dp_mask   (dp_mask),
    .blank     (blank),
    .anode     (anode),
    .seg       (seg),
    .dp        (dp),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Lit segments (active-high, bit0 = a) for each hex value shown on a display.
  function automatic logic [6:0] lit(input int v);
    case (v)
      0: return 7'b0111111;  1: return 7'b0000110;
      2: return 7'b1011011;  3: return 7'b1001111;
      4: return 7'b1100110;  5: return 7'b1101101;
      6: return 7'b1111101;  7: return 7'b0000111;
      8: return 7'b1111111;  9: return 7'b1101111;
      10: return 7'b1000000; 11: return 7'b1111100;
      12: return 7'b0111001; 13: return 7'b1011110;
      14: return 7'b1111001; default: return 7'b0000000;
    endcase
  endfunction

  function automatic exp_t model(input int i);
    exp_t e;
    int   v;
    v = (int'(digits) >> (4*i)) % 16;
    e.idx = i;
    e.an  = blank ? 4'hF : 4'((~(1 << i)) & 15);
    e.sg  = ~lit(v);
    e.dp  = ~dp_mask[i];
`ifdef SEVEN_SEG_LZ_BLANK_EN
    if (i > 0 && (int'(digits) >> (4*i)) == 0 && !dp_mask[i]) e.sg = 7'h7F;
`endif
    return e;
  endfunction

  task automatic rise(input int h, input int l);
    int off;
    off = $urandom_range(1, 4);
    m_idx = (m_idx + 1) % NDIG;
    q.push_back(model(m_idx));
    @(posedge clk); #off;
    scan_clk = 1'b1;
    repeat (h) @(posedge clk);
    #off;
    scan_clk = 1'b0;
    repeat (l) @(posedge clk);
  endtask

  // Monitor: a digit_idx step marks a tick; the slot is checked one clk later.
  int   prev_idx = NDIG - 1;
  bit   pend = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      prev_idx = NDIG - 1;
      pend = 1'b0;
    end else begin
      if (pend) begin
        pend = 1'b0;
        if (q.size() == 0) begin
          chk("unexpected_tick", 32'(digit_idx), 32'hFFFF);
        end else begin
          e = q.pop_front();
          chk("slot_idx",   32'(digit_idx), 32'(e.idx));
          chk("slot_anode", 32'(anode),     32'(e.an));
          chk("slot_seg",   32'(seg),       32'(e.sg));
          chk("slot_dp",    32'(dp),        32'(e.dp));
        end
      end
      if (int'(digit_idx) != prev_idx) begin
        chk("ghost_anode", 32'(anode), 32'hF);
        prev_idx = int'(digit_idx);
        pend = 1'b1;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_anode", 32'(anode), 32'hF);
    chk("rst_seg",   32'(seg),   32'h7F);
    chk("rst_dp",    32'(dp),    32'h1);
    chk("rst_idx",   32'(digit_idx), 32'h3);

    for (int i = 0; i < 8; i++) rise(4, 4);

    @(negedge clk); digits = 16'hABEF; dp_mask = 4'b0100;
    for (int i = 0; i < 4; i++) rise(4, 4);

    @(negedge clk); digits = 16'h0070; dp_mask = 4'b0000;
    for (int i = 0; i < 4; i++) rise(4, 4);

    @(negedge clk); digits = 16'h5678;
    rise(4, 4);
    @(negedge clk); blank = 1'b1;
    @(negedge clk); chk("blank_anode", 32'(anode), 32'hF);
    for (int i = 0; i < 3; i++) rise(4, 4);
    @(negedge clk); blank = 1'b0;
    @(negedge clk); chk("unblank_anode", 32'(anode), 32'((~(1 << m_idx)) & 15));
    rise(4, 4);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      digits  = 16'($urandom);
      dp_mask = 4'($urandom);
      rise(4, $urandom_range(3, 6));
    end

    for (int i = 0; i < 30; i++) begin
      int h;
      h = $urandom_range(1, 2);
      rise(h, $urandom_range(3, 4) - h);
    end
    repeat (8) @(posedge clk);

    rise(4, 4);
    @(negedge clk); #2 rst = 1'b0;
    #1;
    chk("async_rst_anode", 32'(anode), 32'hF);
    chk("async_rst_seg",   32'(seg),   32'h7F);
    chk("async_rst_idx",   32'(digit_idx), 32'h3);
    @(negedge clk); rst = 1'b1;
    m_idx = NDIG - 1;
    @(negedge clk); digits = 16'h9C0D;
    for (int i = 0; i < 4; i++) rise(4, 4);

    repeat (10) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
